// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control unit: Moore FSM sequencing FETCH/DECODE/
// EXEC/MEM/WB with a sticky HALT trap on illegal opcodes and a retired-
// instruction counter.
// Optional feature: define BRANCH_EN to add BEQ (3-cycle branch through EXEC).
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        pc_write_cond,
    output logic        pc_src,
    output logic [2:0]  state,
    output logic        halted,
    output logic [31:0] instret
);

    localparam int unsigned STATE_W = 3;
    localparam int unsigned OP_W    = 7;
    localparam int unsigned CNT_W   = 32;

    localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_EXEC   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEM    = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_WB     = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_HALT   = STATE_W'(5);

    localparam logic [OP_W-1:0] OP_R  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LW = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW = 7'b0100011;
`ifdef BRANCH_EN
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
`endif

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
`ifdef BRANCH_EN
    localparam logic [1:0] ALU_SUB   = 2'b01;
`endif

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [OP_W-1:0]    op_q;
    logic [CNT_W-1:0]   instret_q;
    logic               retire;
    logic               opcode_legal;

    // Opcodes that DECODE accepts; everything else traps to HALT
`ifdef BRANCH_EN
    assign opcode_legal = (opcode == OP_R) || (opcode == OP_I) ||
                          (opcode == OP_LW) || (opcode == OP_SW) ||
                          (opcode == OP_BEQ);
`else
    assign opcode_legal = (opcode == OP_R) || (opcode == OP_I) ||
                          (opcode == OP_LW) || (opcode == OP_SW);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode latch (end of DECODE) and retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            instret_q <= '0;
        end else begin
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    // Next-state logic; retire flags the exit from an instruction's last state
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = opcode_legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                case (op_q)
                    OP_R, OP_I:   state_d = S_WB;
                    OP_LW, OP_SW: state_d = S_MEM;
`ifdef BRANCH_EN
                    OP_BEQ: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
`endif
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (op_q == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore output decode from state and latched opcode, forced idle in reset
    always_comb begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src       = 1'b0;
        alu_op        = ALU_ADD;
        pc_write_cond = 1'b0;
        pc_src        = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
                S_EXEC: begin
                    case (op_q)
                        OP_R: alu_op = ALU_FUNCT;
                        OP_I: begin
                            alu_op  = ALU_FUNCT;
                            alu_src = 1'b1;
                        end
                        OP_LW, OP_SW: alu_src = 1'b1;
`ifdef BRANCH_EN
                        OP_BEQ: begin
                            alu_op        = ALU_SUB;
                            pc_write_cond = 1'b1;
                            pc_src        = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_read  = (op_q == OP_LW);
                    mem_write = (op_q == OP_SW);
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (op_q == OP_LW);
                end
                default: ;
            endcase
        end
    end

    // Status outputs
    assign state   = state_q;
    assign halted  = (state_q == S_HALT) && !rst;
    assign instret = rst ? '0 : instret_q;

endmodule
